multicycle_memory: RTL

MULTICYCLE_MEMORY -- requirements
Module: multicycle_memory

---
 rtl/multicycle_memory_if.sv | 30 +++
 rtl/multicycle_memory.sv | 120 ++++++++++++
 2 files changed

// File: rtl/multicycle_memory_if.sv
// Request/response bus for multicycle_memory.
// The master issues requests; the slave holds each response until it is taken.
interface multicycle_memory_if #(
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [31:0]           req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_wen, req_addr,
        output req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid,
        input  resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr,
        input  req_wdata, req_be, resp_ready,
        output req_ready, resp_valid,
        output resp_rdata, resp_err
    );
endinterface

// File: rtl/multicycle_memory.sv
// Single-port word memory with a fixed request-to-response latency.
// Define MEM_ERR_CHECK_EN to flag misaligned or out-of-range addresses.
module multicycle_memory #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic               clock,
    input  logic               reset,
    multicycle_memory_if.slave bus,
    output logic               busy
);
    localparam int OFF   = (DATA_W == 64) ? 3 : 2;
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (LATENCY > 2) ? CNT_W'(LATENCY - 2) : '0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  wen_q;
    logic                  err_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [BE_W-1:0]       be_q;

    logic [DATA_W-1:0]     mem [0:DEPTH-1];

    logic                  accept;
    logic                  enter_resp;
    logic                  req_err;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  cur_wen;
    logic                  cur_err;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [DATA_W-1:0]     cur_wdata;
    logic [BE_W-1:0]       cur_be;

    assign bus.req_ready = reset && (state == IDLE);
    assign busy          = (state != IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_idx       = bus.req_addr[OFF +: DEPTH_LOG2];

`ifdef MEM_ERR_CHECK_EN
    assign req_err = (bus.req_addr[OFF-1:0] != '0) ||
                     (bus.req_addr[31:OFF+DEPTH_LOG2] != '0);
`else
    assign req_err = 1'b0;
`endif

    // With LATENCY=1 the access happens on the accept edge itself,
    // so the live request fields are used instead of the captured ones.
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == '0));
    assign cur_wen   = (state == IDLE) ? bus.req_wen   : wen_q;
    assign cur_err   = (state == IDLE) ? req_err       : err_q;
    assign cur_idx   = (state == IDLE) ? req_idx       : idx_q;
    assign cur_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
    assign cur_be    = (state == IDLE) ? bus.req_be    : be_q;

    // Capture request fields on the accept edge.
    always_ff @(posedge clock) begin
        if (accept) begin
            wen_q   <= bus.req_wen;
            err_q   <= req_err;
            idx_q   <= req_idx;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    // Sequencing FSM and registered response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= (LATENCY == 1) ? RESP : WAIT;
                    cnt   <= CNT_LOAD;
                end
                WAIT: if (cnt == '0) begin
                    state <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (bus.resp_ready) begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                bus.resp_valid <= 1'b1;
                bus.resp_err   <= cur_err;
                bus.resp_rdata <= cur_err ? '0 : mem[cur_idx];
            end
        end
    end

    // Byte-lane write commit; contents survive reset.
    always_ff @(posedge clock) begin
        if (reset && enter_resp && cur_wen && !cur_err) begin
            for (int b = 0; b < BE_W; b++) begin
                if (cur_be[b]) begin
                    mem[cur_idx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
                end
            end
        end
    end
endmodule
